// File: rtl/hazard_pkg.sv
`default_nettype none
// ============================================================================
// Module   : hazard_pkg
// Brief    : Shared encodings for the pipeline hazard / forwarding controller.
// Revision : 1.0
// ============================================================================
package hazard_pkg;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;

  localparam logic [1:0] LD  = 2'b00;
  localparam logic [1:0] ALU = 2'b10;

  typedef enum logic [0:0] {
    RUN  = 1'b0,
    HOLD = 1'b1
  } hz_state_t;

endpackage
`default_nettype wire

// File: rtl/hazard_forward_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : hazard_forward_unit_if
// Brief    : Pipeline-side register/control bundle seen by the hazard unit.
// Revision : 1.0
// ============================================================================
interface hazard_forward_unit_if #(
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 16
);
  logic [ADDR_W-1:0] id_rs;
  logic [ADDR_W-1:0] id_rt;
  logic [ADDR_W-1:0] ex_rs;
  logic [ADDR_W-1:0] ex_rt;
  logic [ADDR_W-1:0] ex_dst;
  logic              ex_wen;
  logic              ex_is_load;
  logic [ADDR_W-1:0] mem_dst;
  logic              mem_wen;
  logic [ADDR_W-1:0] wb_dst;
  logic              wb_wen;
  logic              branch_taken;
  logic [1:0]        fwd_a;
  logic [1:0]        fwd_b;
  logic              stall;
  logic              bubble_ex;
  logic              flush_id;
  logic [CNT_W-1:0]  stall_cnt;

  modport master (
    output id_rs, id_rt, ex_rs, ex_rt, ex_dst, ex_wen, ex_is_load,
           mem_dst, mem_wen, wb_dst, wb_wen, branch_taken,
    input  fwd_a, fwd_b, stall, bubble_ex, flush_id, stall_cnt
  );

  modport slave (
    input  id_rs, id_rt, ex_rs, ex_rt, ex_dst, ex_wen, ex_is_load,
           mem_dst, mem_wen, wb_dst, wb_wen, branch_taken,
    output fwd_a, fwd_b, stall, bubble_ex, flush_id, stall_cnt
  );
endinterface
`default_nettype wire

// File: rtl/fwd_sel.sv
`default_nettype none
// ============================================================================
// Module   : fwd_sel
// Brief    : Operand bypass select for one EX source; newest producer wins.
// Revision : 1.0
// ============================================================================
module fwd_sel
  import hazard_pkg::*;
#(
  parameter int ADDR_W = 5
) (
  input  logic [ADDR_W-1:0] src,
  input  logic [ADDR_W-1:0] mem_dst,
  input  logic              mem_wen,
  input  logic [ADDR_W-1:0] wb_dst,
  input  logic              wb_wen,
  output logic [1:0]        sel
);

  logic w_src_nz;

  assign w_src_nz = |src;

  always_comb begin
    sel = FWD_RF;
    if (w_src_nz && mem_wen && (mem_dst == src)) begin
      sel = FWD_MEM;
    end else if (w_src_nz && wb_wen && (wb_dst == src)) begin
      sel = FWD_WB;
    end
  end

endmodule
`default_nettype wire

// File: rtl/hazard_forward_unit.sv
`default_nettype none
// ============================================================================
// Module   : hazard_forward_unit
// Brief    : 5-stage pipeline forwarding decode, load-use stall FSM, branch
//            flush and saturating stall statistics.
// Revision : 1.0
// ============================================================================
module hazard_forward_unit
  import hazard_pkg::*;
#(
  parameter int ADDR_W     = 5,
  parameter int LOAD_STALL = 1,
  parameter int FWD_EN     = 1,
  parameter int CNT_W      = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  hazard_forward_unit_if.slave bus
);

  localparam logic [3:0]       c_hold_init = 4'(LOAD_STALL - 1);
  localparam bit               c_use_hold  = (FWD_EN != 0) && (LOAD_STALL > 1);
  localparam bit               c_fwd_on    = (FWD_EN != 0);
  localparam logic [CNT_W-1:0] c_cnt_max   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] c_cnt_one   = {{(CNT_W-1){1'b0}}, 1'b1};

  hz_state_t        r_state;
  logic [3:0]       r_cnt;
  logic [CNT_W-1:0] r_stall_cnt;

  logic [1:0] w_sel_a;
  logic [1:0] w_sel_b;
  logic       w_id_rs_nz;
  logic       w_id_rt_nz;
  logic       w_ex_hit;
  logic       w_mem_hit;
  logic       w_hz;
  logic       w_stall;
  logic       w_bubble;
  logic       w_flush;

  fwd_sel #(.ADDR_W(ADDR_W)) u_fwd_a (
    .src     (bus.ex_rs),
    .mem_dst (bus.mem_dst),
    .mem_wen (bus.mem_wen),
    .wb_dst  (bus.wb_dst),
    .wb_wen  (bus.wb_wen),
    .sel     (w_sel_a)
  );

  fwd_sel #(.ADDR_W(ADDR_W)) u_fwd_b (
    .src     (bus.ex_rt),
    .mem_dst (bus.mem_dst),
    .mem_wen (bus.mem_wen),
    .wb_dst  (bus.wb_dst),
    .wb_wen  (bus.wb_wen),
    .sel     (w_sel_b)
  );

  assign w_id_rs_nz = |bus.id_rs;
  assign w_id_rt_nz = |bus.id_rt;
  assign w_ex_hit   = (w_id_rs_nz && (bus.id_rs == bus.ex_dst)) ||
                      (w_id_rt_nz && (bus.id_rt == bus.ex_dst));
  assign w_mem_hit  = (w_id_rs_nz && (bus.id_rs == bus.mem_dst)) ||
                      (w_id_rt_nz && (bus.id_rt == bus.mem_dst));

  // Without bypassing, any in-flight writer in EX or MEM blocks the ID reader.
  assign w_hz = c_fwd_on ? (bus.ex_is_load && bus.ex_wen && w_ex_hit)
                         : ((bus.ex_wen && w_ex_hit) || (bus.mem_wen && w_mem_hit));

  always_comb begin
    w_stall  = 1'b0;
    w_bubble = 1'b0;
    w_flush  = 1'b0;
    if (!rst_n) begin
      w_stall  = 1'b0;
    end else if (bus.branch_taken) begin
      w_flush  = 1'b1;
      w_bubble = 1'b1;
    end else if ((r_state == HOLD) || w_hz) begin
      w_stall  = 1'b1;
      w_bubble = 1'b1;
    end
  end

  always_comb begin
    bus.fwd_a     = FWD_RF;
    bus.fwd_b     = FWD_RF;
    if (rst_n && c_fwd_on) begin
      bus.fwd_a   = w_sel_a;
      bus.fwd_b   = w_sel_b;
    end
    bus.stall     = w_stall;
    bus.bubble_ex = w_bubble;
    bus.flush_id  = w_flush;
    bus.stall_cnt = r_stall_cnt;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= RUN;
      r_cnt       <= 4'd0;
      r_stall_cnt <= '0;
    end else begin
      if (w_stall && (r_stall_cnt != c_cnt_max)) begin
        r_stall_cnt <= r_stall_cnt + c_cnt_one;
      end
      if (bus.branch_taken) begin
        r_state <= RUN;
        r_cnt   <= 4'd0;
      end else begin
        case (r_state)
          RUN: begin
            if (w_hz && c_use_hold) begin
              r_state <= HOLD;
              r_cnt   <= c_hold_init;
            end
          end
          HOLD: begin
            r_cnt <= r_cnt - 4'd1;
            if (r_cnt == 4'd1) begin
              r_state <= RUN;
            end
          end
          default: begin
            r_state <= RUN;
            r_cnt   <= 4'd0;
          end
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_hazard_forward_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_hazard_forward_unit
// Brief    : Scoreboard bench over four parameterisations of the hazard unit.
// Revision : 1.0
// ============================================================================
module tb_hazard_forward_unit;

  typedef struct {
    int         dut;
    string      tag;
    logic [1:0] fa;
    logic [1:0] fb;
    logic       st;
    logic       bb;
    logic       fl;
    int         cnt;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] id_rs, id_rt, ex_rs, ex_rt, ex_dst, mem_dst, wb_dst;
  logic       ex_wen, ex_is_load, mem_wen, wb_wen, branch_taken;

  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t sb_q[$];

  always #5 clk = ~clk;

  // dut 1: LOAD_STALL=1, dut 3: LOAD_STALL=3, dut 0: no forwarding, dut 4: CNT_W=4
  hazard_forward_unit_if #(.ADDR_W(5), .CNT_W(16)) if1 ();
  hazard_forward_unit_if #(.ADDR_W(5), .CNT_W(16)) if3 ();
  hazard_forward_unit_if #(.ADDR_W(5), .CNT_W(16)) if0 ();
  hazard_forward_unit_if #(.ADDR_W(5), .CNT_W(4))  if4 ();

`define TB_DRIVE(I) \
  assign I.id_rs = id_rs;     assign I.id_rt = id_rt; \
  assign I.ex_rs = ex_rs;     assign I.ex_rt = ex_rt; \
  assign I.ex_dst = ex_dst;   assign I.ex_wen = ex_wen; \
  assign I.ex_is_load = ex_is_load; \
  assign I.mem_dst = mem_dst; assign I.mem_wen = mem_wen; \
  assign I.wb_dst = wb_dst;   assign I.wb_wen = wb_wen; \
  assign I.branch_taken = branch_taken;

  `TB_DRIVE(if1)
  `TB_DRIVE(if3)
  `TB_DRIVE(if0)
  `TB_DRIVE(if4)
`undef TB_DRIVE

  hazard_forward_unit #(.ADDR_W(5), .LOAD_STALL(1), .FWD_EN(1), .CNT_W(16))
    u_dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));
  hazard_forward_unit #(.ADDR_W(5), .LOAD_STALL(3), .FWD_EN(1), .CNT_W(16))
    u_dut3 (.clk(clk), .rst_n(rst_n), .bus(if3));
  hazard_forward_unit #(.ADDR_W(5), .LOAD_STALL(1), .FWD_EN(0), .CNT_W(16))
    u_dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
  hazard_forward_unit #(.ADDR_W(5), .LOAD_STALL(3), .FWD_EN(1), .CNT_W(4))
    u_dut4 (.clk(clk), .rst_n(rst_n), .bus(if4));

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic get_out(input int dut, output logic [1:0] fa, output logic [1:0] fb,
                         output logic st, output logic bb, output logic fl,
                         output logic [31:0] cnt);
    case (dut)
      1: begin fa = if1.fwd_a; fb = if1.fwd_b; st = if1.stall; bb = if1.bubble_ex;
               fl = if1.flush_id; cnt = 32'(if1.stall_cnt); end
      3: begin fa = if3.fwd_a; fb = if3.fwd_b; st = if3.stall; bb = if3.bubble_ex;
               fl = if3.flush_id; cnt = 32'(if3.stall_cnt); end
      0: begin fa = if0.fwd_a; fb = if0.fwd_b; st = if0.stall; bb = if0.bubble_ex;
               fl = if0.flush_id; cnt = 32'(if0.stall_cnt); end
      default: begin fa = if4.fwd_a; fb = if4.fwd_b; st = if4.stall; bb = if4.bubble_ex;
               fl = if4.flush_id; cnt = 32'(if4.stall_cnt); end
    endcase
  endtask

  // Push the expectation, sample mid-cycle, pop and compare, then advance one edge.
  task automatic step(input int dut, input string tag, input logic [1:0] fa,
                      input logic [1:0] fb, input logic st, input logic bb,
                      input logic fl, input int cnt);
    exp_t e;
    logic [1:0] a_fa, a_fb;
    logic a_st, a_bb, a_fl;
    logic [31:0] a_cnt;
    e.dut = dut; e.tag = tag; e.fa = fa; e.fb = fb;
    e.st = st; e.bb = bb; e.fl = fl; e.cnt = cnt;
    sb_q.push_back(e);
    @(negedge clk);
    get_out(sb_q[0].dut, a_fa, a_fb, a_st, a_bb, a_fl, a_cnt);
    e = sb_q.pop_front();
    chk({e.tag, ".fwd_a"},     32'(a_fa), 32'(e.fa));
    chk({e.tag, ".fwd_b"},     32'(a_fb), 32'(e.fb));
    chk({e.tag, ".stall"},     32'(a_st), 32'(e.st));
    chk({e.tag, ".bubble"},    32'(a_bb), 32'(e.bb));
    chk({e.tag, ".flush"},     32'(a_fl), 32'(e.fl));
    chk({e.tag, ".stall_cnt"}, a_cnt,     32'(e.cnt));
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    id_rs = 0; id_rt = 0; ex_rs = 0; ex_rt = 0; ex_dst = 0; mem_dst = 0; wb_dst = 0;
    ex_wen = 0; ex_is_load = 0; mem_wen = 0; wb_wen = 0; branch_taken = 0;
  endtask

  task automatic reset_all();
    clear_inputs();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic load_use();
    ex_is_load = 1; ex_wen = 1; ex_dst = 5; id_rt = 5;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    clear_inputs();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    // Outputs must stay quiet under reset even with a hazard and a bypass present.
    load_use(); ex_rs = 3; mem_dst = 3; mem_wen = 1;
    step(1, "rst1", 2'b00, 2'b00, 0, 0, 0, 0);
    step(3, "rst3", 2'b00, 2'b00, 0, 0, 0, 0);
    step(0, "rst0", 2'b00, 2'b00, 0, 0, 0, 0);
    step(4, "rst4", 2'b00, 2'b00, 0, 0, 0, 0);

    // Forwarding priority and register-0 exclusion
    reset_all();
    ex_rs = 3; mem_dst = 3; mem_wen = 1; wb_dst = 3; wb_wen = 1;
    step(1, "fwd_mem_pri", 2'b01, 2'b00, 0, 0, 0, 0);
    mem_wen = 0;
    step(1, "fwd_wb", 2'b10, 2'b00, 0, 0, 0, 0);
    ex_rt = 0; mem_dst = 0; mem_wen = 1;
    step(1, "fwd_r0", 2'b10, 2'b00, 0, 0, 0, 0);
    ex_rs = 4; ex_rt = 4; wb_dst = 4; mem_dst = 9; mem_wen = 1;
    step(1, "fwd_both_wb", 2'b10, 2'b10, 0, 0, 0, 0);
    ex_rs = 9; ex_rt = 6; mem_dst = 6; wb_wen = 0;
    step(1, "fwd_b_mem", 2'b00, 2'b01, 0, 0, 0, 0);
    ex_rs = 3; mem_dst = 3; mem_wen = 1;
    step(0, "nofwd_const", 2'b00, 2'b00, 0, 0, 0, 0);

    // Load-use, single stall cycle
    reset_all();
    load_use();
    step(1, "ls1_stall", 2'b00, 2'b00, 1, 1, 0, 0);
    ex_is_load = 0; ex_wen = 0; ex_dst = 0; mem_dst = 5; mem_wen = 1;
    step(1, "ls1_release", 2'b00, 2'b00, 0, 0, 0, 1);
    id_rt = 0; ex_rt = 5; mem_wen = 0; wb_dst = 5; wb_wen = 1;
    step(1, "ls1_consume", 2'b00, 2'b10, 0, 0, 0, 1);

    // Load-use, three stall cycles
    reset_all();
    load_use();
    step(3, "ls3_c0", 2'b00, 2'b00, 1, 1, 0, 0);
    ex_is_load = 0; ex_wen = 0; ex_dst = 0;
    step(3, "ls3_c1", 2'b00, 2'b00, 1, 1, 0, 1);
    step(3, "ls3_c2", 2'b00, 2'b00, 1, 1, 0, 2);
    step(3, "ls3_done", 2'b00, 2'b00, 0, 0, 0, 3);

    // Taken branch in the second stall cycle
    reset_all();
    load_use();
    step(3, "br_c0", 2'b00, 2'b00, 1, 1, 0, 0);
    ex_is_load = 0; ex_wen = 0; ex_dst = 0; branch_taken = 1;
    step(3, "br_flush", 2'b00, 2'b00, 0, 1, 1, 1);
    branch_taken = 0;
    step(3, "br_after", 2'b00, 2'b00, 0, 0, 0, 1);
    load_use(); branch_taken = 1;
    step(3, "br_vs_hz", 2'b00, 2'b00, 0, 1, 1, 1);
    clear_inputs();
    step(3, "br_vs_hz_cnt", 2'b00, 2'b00, 0, 0, 0, 1);

    // No forwarding: stall while producer is in EX then MEM
    reset_all();
    ex_wen = 1; ex_dst = 7; id_rs = 7;
    step(0, "nf_ex", 2'b00, 2'b00, 1, 1, 0, 0);
    ex_wen = 0; ex_dst = 0; mem_dst = 7; mem_wen = 1; ex_rs = 7;
    step(0, "nf_mem", 2'b00, 2'b00, 1, 1, 0, 1);
    mem_wen = 0; mem_dst = 0; wb_dst = 7; wb_wen = 1;
    step(0, "nf_wb", 2'b00, 2'b00, 0, 0, 0, 2);
    id_rs = 0; ex_wen = 1; ex_dst = 0; mem_wen = 1; mem_dst = 0;
    step(0, "nf_r0", 2'b00, 2'b00, 0, 0, 0, 2);

    // Saturation at 15, then reset in the middle of a hold
    reset_all();
    load_use();
    for (int i = 0; i < 20; i++) begin
      step(4, $sformatf("sat%0d", i), 2'b00, 2'b00, 1, 1, 0, (i < 15) ? i : 15);
    end
    rst_n = 1'b0;
    step(4, "rst_hold", 2'b00, 2'b00, 0, 0, 0, 15);
    rst_n = 1'b1;
    clear_inputs();
    step(4, "post_rst", 2'b00, 2'b00, 0, 0, 0, 0);
    step(4, "post_rst2", 2'b00, 2'b00, 0, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/hazard_forward_unit.md
Name: hazard_forward_unit

Overview:
- Parametrised hazard and forwarding controller for the 5-stage pipeline (IF/ID/EX/MEM/WB); successor to the per-case hazard flag block.
- Decodes forwarding mux selects for both EX ALU operands from the MEM and WB stages, with newest-producer priority and register-0 exclusion.
- Detects load-use hazards and runs a stall FSM that holds IF/ID for a configurable number of cycles while injecting EX bubbles.
- Handles taken-branch flush and keeps a saturating stall-cycle statistics counter. A no-forwarding mode stalls on every RAW hazard.

Parameters:
- ADDR_W, 5, register address width.
- LOAD_STALL, 1, stall cycles per load-use hazard (1..15).
- FWD_EN, 1, 1 = forwarding enabled; 0 = no forwarding, RAW hazards stall until the producer leaves MEM.
- CNT_W, 16, width of the stall statistics counter.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- id_rs, id_rt  in  ADDR_W  source registers of the instruction in ID
- ex_rs, ex_rt  in  ADDR_W  source registers of the instruction in EX
- ex_dst  in  ADDR_W  destination of the EX instruction
- ex_wen  in  1  EX instruction writes a register
- ex_is_load  in  1  EX instruction is a load (ALUOp 2'b00)
- mem_dst  in  ADDR_W  destination of the MEM instruction
- mem_wen  in  1  MEM instruction writes a register
- wb_dst  in  ADDR_W  destination of the WB instruction
- wb_wen  in  1  WB instruction writes a register
- branch_taken  in  1  branch resolved taken in EX
- fwd_a, fwd_b  out  2  operand select: 00 register file, 01 MEM result, 10 WB result
- stall  out  1  hold PC and the IF/ID register
- bubble_ex  out  1  load a NOP into ID/EX
- flush_id  out  1  zero the IF/ID register
- stall_cnt  out  CNT_W  total stall cycles since reset, saturating

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-low, rst_n.
- Reset: FSM goes to RUN, down-counter to 0, and stall_cnt to 0. While rst_n=0, stall, bubble_ex and flush_id are 0 and fwd_a = fwd_b = 00.
- Forwarding (combinational, zero latency; FWD_EN=1 only). For each of ex_rs/fwd_a and ex_rt/fwd_b:
  - 01 if mem_wen and mem_dst == src and src != 0;
  - else 10 if wb_wen and wb_dst == src and src != 0;
  - else 00.
  - MEM has priority over WB when both match.
- With FWD_EN=0, fwd_a and fwd_b are constant 00.
- Hazard detect (combinational), hz = (id_rs or id_rt matches a producer, register 0 excluded):
  - FWD_EN=1: producer is the EX load only (ex_is_load and ex_wen).
  - FWD_EN=0: producer is EX (ex_wen) or MEM (mem_wen).
- FSM states RUN and HOLD, with a 4-bit down-counter cnt:
  - RUN: if hz and not branch_taken, assert stall and bubble_ex this cycle. If LOAD_STALL > 1, go to HOLD with cnt = LOAD_STALL-1; otherwise stay in RUN.
  - HOLD: assert stall and bubble_ex. Decrement cnt each cycle; go to RUN when cnt reaches 1 and is decremented.
  - In HOLD, hz is ignored. Re-detection on return to RUN is legal and starts a new hold.
  - FWD_EN=0 uses RUN only. Stall lasts while hz holds; bubbles drain the producer naturally.
- Branch: branch_taken asserts flush_id the same cycle and overrides all else:
  - stall = 0 and bubble_ex = 1 (flushes the wrong-path ID instruction);
  - FSM forced to RUN and cnt cleared.
- stall_cnt increments in every cycle where stall = 1 and holds at 2^CNT_W-1.
- Reset mid-HOLD: the next edge returns to RUN. No residual stall cycles.
- Simultaneous hz and branch_taken: the branch wins; no stall is counted.

Decomposition:
- Shared package hazard_pkg holds:
  - forward select constants FWD_RF = 2'b00, FWD_MEM = 2'b01, FWD_WB = 2'b10;
  - ALUOp encodings LD = 2'b00, ALU = 2'b10;
  - FSM state typedef {RUN, HOLD}.
- One natural sub-module, fwd_sel, instantiated twice (operand A and operand B). Inputs: a source register plus the MEM/WB dst and wen signals. Output: a 2-bit select.

Test Plan:
- Forwarding priority, FWD_EN=1: ex_rs=3, mem_dst=3/mem_wen=1, wb_dst=3/wb_wen=1 -> fwd_a=01. Drop mem_wen -> fwd_a=10. Set ex_rt=0 with mem_dst=0 -> fwd_b=00.
- Load-use, LOAD_STALL=1: ex_is_load=1, ex_dst=5, id_rt=5 -> stall=1 and bubble_ex=1 for exactly 1 cycle, then 0 once the bubble is in EX. stall_cnt=1.
- Load-use, LOAD_STALL=3: same stimulus -> stall high for exactly 3 consecutive cycles; stall_cnt=3.
- Branch during HOLD, LOAD_STALL=3: assert branch_taken in the 2nd stall cycle -> that cycle has flush_id=1, bubble_ex=1, stall=0; the next cycle stall=0.
- FWD_EN=0: ex_wen=1, ex_dst=7, id_rs=7, then the producer advances to MEM -> stall high for 2 cycles and fwd_a/fwd_b stay 00. With id_rs=0 and dst=0 -> no stall.
- Reset and saturation, CNT_W=4: hold hz for 20 cycles -> stall_cnt=15. Assert rst_n=0 mid-HOLD -> after one edge, all outputs are 0 and the FSM is in RUN.
